mem_port_arbiter: RTL and testbench

// Shares one 32-bit word memory port between the core's instruction fetch and
// its data load/store path. Arbitrates the two requesters and sequences each

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side signal bundle for mem_port_arbiter.
// master = core + memory model, slave = arbiter.
interface mem_port_arbiter_if;
  logic        halted;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write_en;
  logic [31:0] mem_rdata;
  logic        stall;

  modport master (
    output halted, if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rdata, if_valid,
    input  d_gnt, d_rdata, d_valid,
    input  mem_addr, mem_wdata, mem_write_en,
    input  stall
  );

  modport slave (
    input  halted, if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rdata, if_valid,
    output d_gnt, d_rdata, d_valid,
    output mem_addr, mem_wdata, mem_write_en,
    output stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word memory port between
// instruction fetch and data load/store, fixed latency.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input logic              clk,
  input logic              rst_b,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          last_d;
  logic          own_d;
  logic          is_st;
  logic          accept;
  logic          cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_comb begin
    bus.if_gnt = 1'b0;
    bus.d_gnt  = 1'b0;
    state_nx   = state;
    if (rst_b && state == IDLE && !bus.halted) begin
      unique case (1'b1)
        (bus.if_req & bus.d_req): begin
          bus.d_gnt  = ~last_d;
          bus.if_gnt = last_d;
        end
        (bus.if_req & ~bus.d_req): bus.if_gnt = 1'b1;
        (~bus.if_req & bus.d_req): bus.d_gnt = 1'b1;
        default: ;
      endcase
    end
    accept = (bus.if_req & bus.if_gnt)
           | (bus.d_req & bus.d_gnt);
    unique case (state)
      IDLE: if (accept) state_nx = BUSY;
      BUSY: if (cnt_zero) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.stall = (state == BUSY)
                   | (bus.if_req & bus.d_req)
                   | (bus.halted & (bus.if_req | bus.d_req));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state            <= IDLE;
      cnt              <= '0;
      last_d           <= 1'b0;
      own_d            <= 1'b0;
      is_st            <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.mem_write_en <= 1'b0;
      bus.if_rdata     <= '0;
      bus.if_valid     <= 1'b0;
      bus.d_rdata      <= '0;
      bus.d_valid      <= 1'b0;
    end else begin
      state            <= state_nx;
      bus.if_valid     <= 1'b0;
      bus.d_valid      <= 1'b0;
      bus.mem_write_en <= 1'b0;
      if (accept) begin
        bus.mem_addr     <= bus.d_gnt
                          ? {bus.d_addr[31:2], 2'b00}
                          : {bus.if_addr[31:2], 2'b00};
        bus.mem_wdata    <= bus.d_wdata;
        bus.mem_write_en <= bus.d_gnt & bus.d_we;
        last_d           <= bus.d_gnt;
        own_d            <= bus.d_gnt;
        is_st            <= bus.d_gnt & bus.d_we;
        cnt              <= CNT_LOAD;
      end else if (state == BUSY) begin
        if (cnt_zero) begin
          if (own_d) begin
            bus.d_valid <= 1'b1;
            if (!is_st) bus.d_rdata <= bus.mem_rdata;
          end else begin
            bus.if_valid <= 1'b1;
            bus.if_rdata <= bus.mem_rdata;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  ap_lat: assert property (@(posedge clk) MEM_LATENCY >= 1);

  ap_if_hold: assert property (@(posedge clk) disable iff (!rst_b)
    (bus.if_req && !bus.if_gnt) |=> bus.if_req);

  ap_d_hold: assert property (@(posedge clk) disable iff (!rst_b)
    (bus.d_req && !bus.d_gnt) |=> bus.d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table
// plus hand sequences for conflicts, halt, reset and latency 1.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_b;
  int   total;
  int   bad;

  mem_port_arbiter_if b2 ();
  mem_port_arbiter_if b1 ();

  mem_port_arbiter #(.MEM_LATENCY(2)) u2 (
    .clk(clk), .rst_b(rst_b), .bus(b2.slave));
  mem_port_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .rst_b(rst_b), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir, dr, we, h;
    logic [31:0] ia, da, wd, mr;
    logic        ig, dg, st;
    logic [31:0] ma;
    logic        mwe;
    logic [31:0] mwd;
    logic        iv;
    logic [31:0] ird;
    logic        dv;
    logic [31:0] drd;
  } vec_t;

  vec_t tbl [17];

  localparam logic [31:0] FI = 32'h2008_0005;
  localparam logic [31:0] BE = 32'hDEAD_BEEF;
  localparam logic [31:0] LD = 32'hCAFE_F00D;
  localparam logic [31:0] F2 = 32'h0123_4567;
  localparam logic [31:0] W1 = 32'h1111_1111;
  localparam logic [31:0] G1 = 32'h0BAD_0001;
  localparam logic [31:0] G2 = 32'h0BAD_0002;
  localparam logic [31:0] G3 = 32'h0BAD_0003;
  localparam logic [31:0] ST = 32'h1234_5678;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    b2.halted = 0; b2.if_req = 0; b2.if_addr = 0;
    b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0;
    b2.d_wdata = 0; b2.mem_rdata = 0;
    b1.halted = 0; b1.if_req = 0; b1.if_addr = 0;
    b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0;
    b1.d_wdata = 0; b1.mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  task automatic drive(input vec_t v);
    b2.if_req = v.ir; b2.d_req = v.dr;
    b2.d_we = v.we; b2.halted = v.h;
    b2.if_addr = v.ia; b2.d_addr = v.da;
    b2.d_wdata = v.wd; b2.mem_rdata = v.mr;
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk($sformatf("r%0d if_gnt", i), 32'(b2.if_gnt), 32'(v.ig));
    chk($sformatf("r%0d d_gnt", i), 32'(b2.d_gnt), 32'(v.dg));
    chk($sformatf("r%0d stall", i), 32'(b2.stall), 32'(v.st));
    chk($sformatf("r%0d mem_addr", i), b2.mem_addr, v.ma);
    chk($sformatf("r%0d mem_we", i), 32'(b2.mem_write_en), 32'(v.mwe));
    chk($sformatf("r%0d mem_wdata", i), b2.mem_wdata, v.mwd);
    chk($sformatf("r%0d if_valid", i), 32'(b2.if_valid), 32'(v.iv));
    chk($sformatf("r%0d if_rdata", i), b2.if_rdata, v.ird);
    chk($sformatf("r%0d d_valid", i), 32'(b2.d_valid), 32'(v.dv));
    chk($sformatf("r%0d d_rdata", i), b2.d_rdata, v.drd);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_b = 1'b0;
    idle_inputs();

    //          ir dr we h  ia      da     wd  mr  | ig dg st ma      mwe mwd iv ird dv drd
    tbl[0]  = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  0,    0, 0, 0, 32'h0,   0, 0,  0, 0,  0, 0};
    tbl[1]  = '{1, 0, 0, 0, 32'h406,32'h0, 0,  G1,   1, 0, 0, 32'h0,   0, 0,  0, 0,  0, 0};
    tbl[2]  = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  G2,   0, 0, 1, 32'h404, 0, 0,  0, 0,  0, 0};
    tbl[3]  = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  FI,   0, 0, 1, 32'h404, 0, 0,  0, 0,  0, 0};
    tbl[4]  = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  G3,   0, 0, 0, 32'h404, 0, 0,  1, FI, 0, 0};
    tbl[5]  = '{0, 1, 1, 0, 32'h0,  32'h10,BE, G1,   0, 1, 0, 32'h404, 0, 0,  0, FI, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  ST,   0, 0, 1, 32'h10,  1, BE, 0, FI, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  ST,   0, 0, 1, 32'h10,  0, BE, 0, FI, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  0,    0, 0, 0, 32'h10,  0, BE, 0, FI, 1, 0};
    tbl[9]  = '{0, 1, 0, 0, 32'h0,  32'h23,W1, G1,   0, 1, 0, 32'h10,  0, BE, 0, FI, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  G2,   0, 0, 1, 32'h20,  0, W1, 0, FI, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  LD,   0, 0, 1, 32'h20,  0, W1, 0, FI, 0, 0};
    tbl[12] = '{1, 0, 0, 1, 32'h8,  32'h0, 0,  G3,   0, 0, 1, 32'h20,  0, W1, 0, FI, 1, LD};
    tbl[13] = '{1, 0, 0, 0, 32'h8,  32'h0, 0,  G1,   1, 0, 0, 32'h20,  0, W1, 0, FI, 0, LD};
    tbl[14] = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  G2,   0, 0, 1, 32'h8,   0, 0,  0, FI, 0, LD};
    tbl[15] = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  F2,   0, 0, 1, 32'h8,   0, 0,  0, FI, 0, LD};
    tbl[16] = '{0, 0, 0, 0, 32'h0,  32'h0, 0,  G3,   0, 0, 0, 32'h8,   0, 0,  1, F2, 0, LD};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1 drive(tbl[i]);
      @(negedge clk);
      check_row(i, tbl[i]);
    end

    // Continuous conflict: D, IF, D, IF every 3 cycles
    do_reset();
    @(posedge clk);
    #1 b2.if_req = 1; b2.d_req = 1;
    b2.if_addr = 32'h200; b2.d_addr = 32'h300;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d d_gnt", k), 32'(b2.d_gnt), 32'(k % 6 == 0));
      chk($sformatf("rr%0d if_gnt", k), 32'(b2.if_gnt), 32'(k % 6 == 3));
      chk($sformatf("rr%0d stall", k), 32'(b2.stall), 32'd1);
      @(posedge clk);
      #1;
    end

    // Halt raised while a load is in flight
    do_reset();
    @(posedge clk);
    #1 b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h40;
    @(negedge clk);
    chk("halt d_gnt", 32'(b2.d_gnt), 32'd1);
    @(posedge clk);
    #1 b2.d_req = 0; b2.halted = 1; b2.if_req = 1;
    @(negedge clk);
    chk("halt busy stall", 32'(b2.stall), 32'd1);
    @(posedge clk);
    #1 b2.mem_rdata = 32'h55AA_33CC;
    @(posedge clk);
    #1 b2.mem_rdata = 32'h0;
    @(negedge clk);
    chk("halt d_valid", 32'(b2.d_valid), 32'd1);
    chk("halt d_rdata", b2.d_rdata, 32'h55AA_33CC);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("halt%0d if_gnt", k), 32'(b2.if_gnt), 32'd0);
      chk($sformatf("halt%0d d_gnt", k), 32'(b2.d_gnt), 32'd0);
      chk($sformatf("halt%0d stall", k), 32'(b2.stall), 32'd1);
      @(negedge clk);
    end

    // Reset pulse during the first busy cycle of a store
    do_reset();
    @(posedge clk);
    #1 b2.d_req = 1; b2.d_we = 1;
    b2.d_addr = 32'h80; b2.d_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("rst d_gnt", 32'(b2.d_gnt), 32'd1);
    @(posedge clk);
    #1 b2.d_req = 0; b2.d_we = 0;
    @(negedge clk);
    chk("rst mwe before", 32'(b2.mem_write_en), 32'd1);
    #1 rst_b = 1'b0;
    #1;
    chk("rst mwe async", 32'(b2.mem_write_en), 32'd0);
    chk("rst mem_addr", b2.mem_addr, 32'h0);
    chk("rst mem_wdata", b2.mem_wdata, 32'h0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst%0d d_valid", k), 32'(b2.d_valid), 32'd0);
      chk($sformatf("rst%0d stall", k), 32'(b2.stall), 32'd0);
    end
    @(posedge clk);
    #1 b2.if_req = 1; b2.d_req = 1;
    @(negedge clk);
    chk("rst conflict d_gnt", 32'(b2.d_gnt), 32'd1);
    chk("rst conflict if_gnt", 32'(b2.if_gnt), 32'd0);

    // Latency 1: back-to-back fetches every 2 cycles
    do_reset();
    @(posedge clk);
    #1 b1.if_req = 1; b1.if_addr = 32'h101;
    b1.mem_rdata = 32'hA000_0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("l1_%0d if_gnt", k), 32'(b1.if_gnt),
          32'(k % 2 == 0));
      chk($sformatf("l1_%0d if_valid", k), 32'(b1.if_valid),
          32'(k >= 2 && k % 2 == 0));
      if (k >= 2 && k % 2 == 0)
        chk($sformatf("l1_%0d if_rdata", k), b1.if_rdata,
            32'hA000_0000 + 32'(k - 1));
      if (k % 2 == 1)
        chk($sformatf("l1_%0d mem_addr", k), b1.mem_addr, 32'h100);
      @(posedge clk);
      #1 b1.mem_rdata = 32'hA000_0000 + 32'(k + 1);
    end

    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
